// File: rtl/mix_columns_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mix_columns_seq: sequential AES MixColumns, one 32-bit column per cycle.  |
// | Optional inverse transform enabled by macro MIX_COLUMNS_INV_EN.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         inv,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_col;
  logic [127:0] r_work;
  logic [31:0]  w_col_in;
  logic [31:0]  w_col_out;
  logic         w_accept;
  logic         w_consume;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Row 0 of each column sits in the most significant byte.
  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;
    a0 = col[31:24]; a1 = col[23:16]; a2 = col[15:8]; a3 = col[7:0];
    x0 = xtime(a0);  x1 = xtime(a1);  x2 = xtime(a2); x3 = xtime(a3);
    return {x0 ^ (x1 ^ a1) ^ a2 ^ a3,
            a0 ^ x1 ^ (x2 ^ a2) ^ a3,
            a0 ^ a1 ^ x2 ^ (x3 ^ a3),
            (x0 ^ a0) ^ a1 ^ a2 ^ x3};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  logic r_inv;

  // 9 = x8^1, B = x8^x2^1, D = x8^x4^1, E = x8^x4^x2 from chained xtime.
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] a   [4];
    logic [7:0] m9  [4];
    logic [7:0] mb  [4];
    logic [7:0] md  [4];
    logic [7:0] me  [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inv <= 1'b0;
    end else if (w_accept) begin
      r_inv <= inv;
    end
  end

  assign w_col_out = r_inv ? mix_inv(w_col_in) : mix_fwd(w_col_in);
`else
  assign w_col_out = mix_fwd(w_col_in);
`endif

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_consume = out_ready && (r_state == S_DONE);

  always_comb begin
    w_col_in = r_work[127:96];
    case (r_col)
      2'd0:    w_col_in = r_work[127:96];
      2'd1:    w_col_in = r_work[95:64];
      2'd2:    w_col_in = r_work[63:32];
      default: w_col_in = r_work[31:0];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_col == 2'd3) w_state_nxt = S_DONE;
      S_DONE:  if (w_consume) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter wraps 3->0 naturally on the final BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= 2'd0;
      r_work <= 128'd0;
    end else if (w_accept) begin
      r_col  <= 2'd0;
      r_work <= in_data;
    end else if (r_state == S_BUSY) begin
      r_col <= r_col + 2'd1;
      case (r_col)
        2'd0:    r_work[127:96] <= w_col_out;
        2'd1:    r_work[95:64]  <= w_col_out;
        2'd2:    r_work[63:32]  <= w_col_out;
        default: r_work[31:0]   <= w_col_out;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_work;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mix_columns_seq: self-checking bench with a GF(2^8) matrix model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         busy;
`ifdef MIX_COLUMNS_INV_EN
  logic         inv = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MIX_COLUMNS_INV_EN
    .inv       (inv),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Carry-less product followed by long division by the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input bit inv_m);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] r;
    r = '0;
    if (inv_m) begin
      m[0] = 8'h0E; m[1] = 8'h0B; m[2] = 8'h0D; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(m[(k - rr + 4) % 4], s[127-8*(4*c+k) -: 8]);
        r[127-8*(4*c+rr) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input logic [127:0] d, input bit iv, input string tag);
    logic [127:0] exp;
    int waitc;
    exp   = model(d, iv);
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    check({tag, " in_ready"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_data  = d;
`ifdef MIX_COLUMNS_INV_EN
    inv = iv;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = rand128();
`ifdef MIX_COLUMNS_INV_EN
    inv = ~iv;
`endif
    check({tag, " busy"}, 128'(busy), 128'd1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check({tag, " out_valid timing"}, 128'(out_valid), 128'(k == 4));
    end
    check({tag, " out_data"}, out_data, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid after consume"}, 128'(out_valid), 128'd0);
    check({tag, " in_ready after consume"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] exp;
    logic [127:0] q[$];
    int seen, results, last_acc, cyc;
    bit iv;

    // Reset state while rst_n is low
    #1;
    check("reset in_ready", 128'(in_ready), 128'd1);
    check("reset busy", 128'(busy), 128'd0);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset out_data", out_data, 128'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // First block accepted on the first edge after release
    run_block({32'hDB135345, 96'd0}, 1'b0, "column");
    check("column literal", out_data, {32'h8E4DA1BC, 96'd0});

    run_block(128'hD4BF5D30E0B452AEB84111F11E2798E5, 1'b0, "fips");
    check("fips literal", out_data, 128'h046681E5E0CB199A48F8D37A2806264C);

`ifdef MIX_COLUMNS_INV_EN
    run_block(128'h046681E5E0CB199A48F8D37A2806264C, 1'b1, "fips inv");
    check("fips inv literal", out_data, 128'hD4BF5D30E0B452AEB84111F11E2798E5);
`endif

    for (int i = 0; i < 3; i++) begin
`ifdef MIX_COLUMNS_INV_EN
      iv = 1'($urandom_range(0, 1));
`else
      iv = 1'b0;
`endif
      run_block(rand128(), iv, "random");
    end

    // Backpressure: ten stalled cycles in DONE with a competing request
    d   = rand128();
    exp = model(d, 1'b0);
    in_valid = 1'b1;
    in_data  = d;
`ifdef MIX_COLUMNS_INV_EN
    inv = 1'b0;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp out_valid entry", 128'(out_valid), 128'd1);
    in_valid = 1'b1;
    in_data  = rand128();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp out_valid", 128'(out_valid), 128'd1);
      check("bp out_data", out_data, exp);
      check("bp in_ready", 128'(in_ready), 128'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp idle in_ready", 128'(in_ready), 128'd1);
    check("bp idle busy", 128'(busy), 128'd0);
    check("bp second request ignored", out_data, exp);

    // Reset asserted in the second BUSY cycle
    in_valid = 1'b1;
    in_data  = rand128();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst busy before", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("rst in_ready", 128'(in_ready), 128'd1);
    check("rst busy", 128'(busy), 128'd0);
    check("rst out_valid", 128'(out_valid), 128'd0);
    check("rst out_data", out_data, 128'd0);
    #3 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("rst no out_valid pulse", 128'(seen), 128'd0);
    run_block(rand128(), 1'b0, "post reset");

    // Back-to-back streaming with input data changing every cycle
    in_valid  = 1'b1;
    out_ready = 1'b1;
    results   = 0;
    last_acc  = -1;
    cyc       = 0;
    while (results < 8 && cyc < 200) begin
      in_data = rand128();
`ifdef MIX_COLUMNS_INV_EN
      inv = 1'($urandom_range(0, 1));
      iv  = inv;
`else
      iv  = 1'b0;
`endif
      if (out_valid) begin
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        check("b2b out_data", out_data, exp);
        results++;
      end
      if (in_ready) begin
        q.push_back(model(in_data, iv));
        if (last_acc >= 0)
          check("b2b accept interval", 128'(cyc - last_acc), 128'd6);
        last_acc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b result count", 128'(results), 128'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
